// File: rtl/hazard_unit_mc.sv
// Hazard and forwarding unit for the 5-stage RISC-V pipeline.
// It holds a mul/div in E through a multi-cycle FSM and counts stall cycles.
module hazard_unit_mc #(
    parameter int REG_AW     = 5,
    parameter int MC_LATENCY = 4,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] Rs1E,
    input  logic [REG_AW-1:0] Rs2E,
    input  logic [REG_AW-1:0] RdE,
    input  logic [REG_AW-1:0] RdM,
    input  logic [REG_AW-1:0] RdW,
    input  logic              RegWriteM,
    input  logic              RegWriteW,
    input  logic              ResultSrcE0,
    input  logic              PCSrcE,
    input  logic              MultiCycleE,
    output logic [1:0]        ForwardAE,
    output logic [1:0]        ForwardBE,
    output logic              StallF,
    output logic              StallD,
    output logic              StallE,
    output logic              FlushD,
    output logic              FlushE,
    output logic              FlushM,
    output logic              McBusy,
    output logic [CNT_W-1:0]  StallCount
);

    // A one-bit counter is kept when MC_LATENCY=1 so the vector stays legal.
    localparam int CW = (MC_LATENCY > 1) ? $clog2(MC_LATENCY) : 1;
    localparam bit MC_EN = (MC_LATENCY > 1);
    localparam logic [CW-1:0] CNT_LOAD =
        CW'((MC_LATENCY > 1) ? (MC_LATENCY - 2) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_mc_cnt;
    logic [CNT_W-1:0]   r_stall_cnt;

    logic               w_lw_stall;
    logic               w_mc_last;
    logic               w_mc_stall;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (rs != '0 && we_m && rs == rd_m)
            sel = 2'b10;
        else if (rs != '0 && we_w && rs == rd_w)
            sel = 2'b01;
        return sel;
    endfunction

    // Operand bypass select; the younger M result beats the W result.
    always_comb begin
        ForwardAE = fwd_sel(Rs1E, RdM, RegWriteM, RdW, RegWriteW);
        ForwardBE = fwd_sel(Rs2E, RdM, RegWriteM, RdW, RegWriteW);
    end

    // Load-use and multi-cycle stall decode, plus flush generation.
    always_comb begin
        w_lw_stall = ResultSrcE0 && (RdE != '0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
        w_mc_last  = (r_state == S_BUSY) && (r_mc_cnt == '0);
        w_mc_stall = MultiCycleE && MC_EN && !w_mc_last;
        StallF     = w_lw_stall || w_mc_stall;
        StallD     = w_lw_stall || w_mc_stall;
        StallE     = w_mc_stall;
        FlushM     = w_mc_stall;
        FlushE     = (w_lw_stall && !w_mc_stall) || PCSrcE;
        FlushD     = PCSrcE;
        McBusy     = (r_state == S_BUSY);
        StallCount = r_stall_cnt;
    end

    // Multi-cycle FSM: counts down the remaining held cycles of the op in E.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mc_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (MultiCycleE && MC_EN && !PCSrcE) begin
                        r_state  <= S_BUSY;
                        r_mc_cnt <= CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (r_mc_cnt != '0)
                        r_mc_cnt <= r_mc_cnt - CW'(1);
                    else
                        r_state <= S_IDLE;
                end
                default: begin
                    r_state  <= S_IDLE;
                    r_mc_cnt <= '0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which fetch was held.
    always_ff @(posedge clk) begin
        if (reset)
            r_stall_cnt <= '0;
        else if (StallF && r_stall_cnt != CNT_MAX)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Self-checking bench for hazard_unit_mc: vector table, directed
// multi-cycle sequences and a randomized run against an occupancy model.
module tb_hazard_unit_mc;

    localparam int LAT  = 4;
    localparam int MAXC = 65535;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, ResultSrcE0, PCSrcE, MultiCycleE;

    logic [1:0]  ForwardAE, ForwardBE;
    logic        StallF, StallD, StallE, FlushD, FlushE, FlushM, McBusy;
    logic [15:0] StallCount;

    logic [1:0]  l1_FA, l1_FB;
    logic        l1_SF, l1_SD, l1_SE, l1_FD, l1_FE, l1_FM, l1_Busy;
    logic [15:0] l1_Cnt;

    logic [1:0]  s_FA, s_FB;
    logic        s_SF, s_SD, s_SE, s_FD, s_FE, s_FM, s_Busy;
    logic [3:0]  s_Cnt;

    always #5 clk = ~clk;

    hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(LAT), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MultiCycleE(MultiCycleE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .McBusy(McBusy), .StallCount(StallCount)
    );

    hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(1), .CNT_W(16)) u_l1 (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MultiCycleE(MultiCycleE),
        .ForwardAE(l1_FA), .ForwardBE(l1_FB),
        .StallF(l1_SF), .StallD(l1_SD), .StallE(l1_SE),
        .FlushD(l1_FD), .FlushE(l1_FE), .FlushM(l1_FM),
        .McBusy(l1_Busy), .StallCount(l1_Cnt)
    );

    hazard_unit_mc #(.REG_AW(5), .MC_LATENCY(LAT), .CNT_W(4)) u_sat (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RdE(RdE), .RdM(RdM), .RdW(RdW),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
        .ResultSrcE0(ResultSrcE0), .PCSrcE(PCSrcE),
        .MultiCycleE(MultiCycleE),
        .ForwardAE(s_FA), .ForwardBE(s_FB),
        .StallF(s_SF), .StallD(s_SD), .StallE(s_SE),
        .FlushD(s_FD), .FlushE(s_FE), .FlushM(s_FM),
        .McBusy(s_Busy), .StallCount(s_Cnt)
    );

    typedef struct {
        logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
        logic       rwm, rww, ld, pcs;
        logic [1:0] fa, fb;
        logic       sf, fe, fd;
    } vec_t;

    vec_t vecs[10];
    int   errors = 0;
    int   checks = 0;
    int   age    = 0;
    int   mcount = 0;
    int   exp_st[4];
    int   exp_bz[4];

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     n, act, exp, $time);
        end
    endtask

    function automatic int ref_fwd(input logic [4:0] rs);
        if (rs == 0) return 0;
        if (RegWriteM && rs == RdM) return 2;
        if (RegWriteW && rs == RdW) return 1;
        return 0;
    endfunction

    // Model: 'age' is how many cycles the current multi-cycle op has
    // already spent in E; it stalls until it reaches its last cycle.
    task automatic samp();
        int  lw, mc, sf;
        @(negedge clk);
        lw = (ResultSrcE0 && RdE != 0 && (RdE == Rs1D || RdE == Rs2D)) ? 1 : 0;
        mc = (MultiCycleE && age < LAT - 1) ? 1 : 0;
        sf = lw | mc;
        chk("fwdA",   32'(ForwardAE), 32'(ref_fwd(Rs1E)));
        chk("fwdB",   32'(ForwardBE), 32'(ref_fwd(Rs2E)));
        chk("stallF", 32'(StallF), 32'(sf));
        chk("stallD", 32'(StallD), 32'(sf));
        chk("stallE", 32'(StallE), 32'(mc));
        chk("flushM", 32'(FlushM), 32'(mc));
        chk("flushE", 32'(FlushE), 32'((lw && !mc) || PCSrcE));
        chk("flushD", 32'(FlushD), 32'(PCSrcE));
        chk("mcBusy", 32'(McBusy), 32'(age > 0));
        chk("count",  32'(StallCount), 32'(mcount));
        if (reset) begin
            age    = 0;
            mcount = 0;
        end else begin
            if (sf != 0 && mcount < MAXC) mcount++;
            if (age > 0)
                age = (age == LAT - 1) ? 0 : age + 1;
            else if (MultiCycleE && !PCSrcE)
                age = 1;
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        Rs1D = 0; Rs2D = 0; Rs1E = 0; Rs2E = 0;
        RdE = 0; RdM = 0; RdW = 0;
        RegWriteM = 0; RegWriteW = 0;
        ResultSrcE0 = 0; PCSrcE = 0; MultiCycleE = 0;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1;
        samp();
        adv();
        reset = 0;
    endtask

    initial begin
        vecs[0] = '{0,0,5,0,0,5,5,1,1,0,0, 2'b10,2'b00,0,0,0};
        vecs[1] = '{0,0,5,0,0,5,5,0,1,0,0, 2'b01,2'b00,0,0,0};
        vecs[2] = '{0,0,0,3,0,4,3,1,1,0,0, 2'b00,2'b01,0,0,0};
        vecs[3] = '{0,0,0,3,0,3,3,1,0,0,0, 2'b00,2'b10,0,0,0};
        vecs[4] = '{0,7,0,0,7,0,0,0,0,1,0, 2'b00,2'b00,1,1,0};
        vecs[5] = '{0,0,0,0,0,0,0,0,0,1,0, 2'b00,2'b00,0,0,0};
        vecs[6] = '{7,0,0,0,7,0,0,0,0,1,0, 2'b00,2'b00,1,1,0};
        vecs[7] = '{7,0,0,0,7,0,0,0,0,0,0, 2'b00,2'b00,0,0,0};
        vecs[8] = '{0,7,0,0,7,0,0,0,0,1,1, 2'b00,2'b00,1,1,1};
        vecs[9] = '{0,0,0,0,0,0,0,0,0,0,1, 2'b00,2'b00,0,1,1};
        exp_st = '{1, 1, 1, 0};
        exp_bz = '{0, 1, 1, 1};

        clear_in();
        reset = 1;
        @(posedge clk);
        #1;
        adv();
        reset = 0;

        // Reset state
        samp();
        chk("rst_busy",  32'(McBusy), 32'd0);
        chk("rst_count", 32'(StallCount), 32'd0);
        adv();

        // Vector table
        for (int i = 0; i < 10; i++) begin
            Rs1D = vecs[i].rs1d; Rs2D = vecs[i].rs2d;
            Rs1E = vecs[i].rs1e; Rs2E = vecs[i].rs2e;
            RdE = vecs[i].rde; RdM = vecs[i].rdm; RdW = vecs[i].rdw;
            RegWriteM = vecs[i].rwm; RegWriteW = vecs[i].rww;
            ResultSrcE0 = vecs[i].ld; PCSrcE = vecs[i].pcs;
            MultiCycleE = 0;
            samp();
            chk("vec_fa", 32'(ForwardAE), 32'(vecs[i].fa));
            chk("vec_fb", 32'(ForwardBE), 32'(vecs[i].fb));
            chk("vec_sf", 32'(StallF), 32'(vecs[i].sf));
            chk("vec_fe", 32'(FlushE), 32'(vecs[i].fe));
            chk("vec_fd", 32'(FlushD), 32'(vecs[i].fd));
            adv();
        end

        // Multi-cycle op held for LAT cycles; LAT=1 build must never stall
        do_reset();
        MultiCycleE = 1;
        for (int i = 0; i < 4; i++) begin
            samp();
            chk("mc_stallE", 32'(StallE), 32'(exp_st[i]));
            chk("mc_flushM", 32'(FlushM), 32'(exp_st[i]));
            chk("mc_busy",   32'(McBusy), 32'(exp_bz[i]));
            chk("l1_stallF", 32'(l1_SF), 32'd0);
            chk("l1_stallE", 32'(l1_SE), 32'd0);
            chk("l1_busy",   32'(l1_Busy), 32'd0);
            adv();
        end
        MultiCycleE = 0;
        samp();
        chk("mc_busy_end", 32'(McBusy), 32'd0);
        chk("mc_count",    32'(StallCount), 32'd3);
        chk("l1_count",    32'(l1_Cnt), 32'd0);
        adv();

        // Reset during the second BUSY cycle, then a full restart
        do_reset();
        MultiCycleE = 1;
        samp(); adv();
        samp(); adv();
        reset = 1;
        samp();
        chk("mid_busy", 32'(McBusy), 32'd1);
        adv();
        reset = 0;
        samp();
        chk("post_rst_busy",  32'(McBusy), 32'd0);
        chk("post_rst_count", 32'(StallCount), 32'd0);
        chk("post_rst_stall", 32'(StallE), 32'd1);
        adv();
        samp(); adv();
        samp(); adv();
        samp();
        chk("restart_last", 32'(StallE), 32'd0);
        adv();
        MultiCycleE = 0;
        samp();
        chk("restart_count", 32'(StallCount), 32'd3);
        adv();

        // Randomized run against the occupancy model
        do_reset();
        for (int i = 0; i < 600; i++) begin
            reset = ($urandom_range(0, 59) == 0);
            Rs1D = 5'($urandom_range(0, 3));
            Rs2D = 5'($urandom_range(0, 3));
            Rs1E = 5'($urandom_range(0, 3));
            Rs2E = 5'($urandom_range(0, 3));
            RdE  = 5'($urandom_range(0, 3));
            RdM  = 5'($urandom_range(0, 3));
            RdW  = 5'($urandom_range(0, 3));
            RegWriteM   = 1'($urandom_range(0, 1));
            RegWriteW   = 1'($urandom_range(0, 1));
            ResultSrcE0 = 1'($urandom_range(0, 1));
            if (age > 0)
                MultiCycleE = 1;
            else
                MultiCycleE = ($urandom_range(0, 3) == 0);
            PCSrcE = MultiCycleE ? 1'b0 : ($urandom_range(0, 5) == 0);
            samp();
            adv();
        end

        // Forced load-use stalls saturate the narrow counter
        do_reset();
        ResultSrcE0 = 1; RdE = 7; Rs2D = 7;
        for (int i = 0; i < 20; i++) begin
            samp();
            if (i == 16) chk("sat_reached", 32'(s_Cnt), 32'd15);
            adv();
        end
        clear_in();
        samp();
        chk("sat_hold",   32'(s_Cnt), 32'd15);
        chk("wide_count", 32'(StallCount), 32'd20);
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
